// File: rtl/shift_seq_pkg.sv
// Shared types for the sequential shift unit.
//   op_e    : 4-bit operation codes (9..15 are illegal)
//   state_e : controller states
package shift_seq_pkg;

  typedef enum logic [3:0] {
    OpClr  = 4'd0,
    OpLoad = 4'd1,
    OpSrl  = 4'd2,
    OpSll  = 4'd3,
    OpRor  = 4'd4,
    OpRol  = 4'd5,
    OpSri  = 4'd6,
    OpSli  = 4'd7,
    OpSra  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd8;

endpackage

// File: rtl/shift_seq_unit_if.sv
// Request/response bundle of the shift unit.
//   master : controller side (drives en/start/op/din/amt/sin)
//   slave  : shift unit side (drives dout/sout/busy/done/err)
interface shift_seq_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH + 1)
);
  logic             en;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] din;
  logic [AMT_W-1:0] amt;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output en, start, op, din, amt, sin,
    input  dout, sout, busy, done, err
  );

  modport slave (
    input  en, start, op, din, amt, sin,
    output dout, sout, busy, done, err
  );
endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
//   op_i      : operation (non-shift codes pass data through)
//   d_i       : current value
//   sin_i     : serial bit inserted by SRI/SLI
//   q_o       : value after one step
//   out_bit_o : bit leaving the register on this step
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             out_bit_o
);

  always_comb begin
    q_o       = d_i;
    out_bit_o = 1'b0;
    case (op_i)
      OpSrl: begin q_o = {1'b0, d_i[WIDTH-1:1]};        out_bit_o = d_i[0];       end
      OpSll: begin q_o = {d_i[WIDTH-2:0], 1'b0};        out_bit_o = d_i[WIDTH-1]; end
      OpRor: begin q_o = {d_i[0], d_i[WIDTH-1:1]};      out_bit_o = d_i[0];       end
      OpRol: begin q_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]}; out_bit_o = d_i[WIDTH-1]; end
      OpSri: begin q_o = {sin_i, d_i[WIDTH-1:1]};       out_bit_o = d_i[0];       end
      OpSli: begin q_o = {d_i[WIDTH-2:0], sin_i};       out_bit_o = d_i[WIDTH-1]; end
      OpSra: begin q_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]}; out_bit_o = d_i[0];       end
      default: begin q_o = d_i; out_bit_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequential shift unit: runs a multi-bit shift/rotate as one 1-bit step per enabled clock,
// with a start/busy/done handshake and an illegal-op error flag.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_seq_unit_if.slave   bus
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sout_q, sout_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_q;
  logic             step_out;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i      (op_q),
    .d_i       (dout_q),
    .sin_i     (bus.sin),
    .q_o       (step_q),
    .out_bit_o (step_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    err_d   = err_q;
    if (bus.en) begin
      case (state_q)
        StShift: begin
          dout_d = step_q;
          sout_d = step_out;
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_d = StDone;
        end
        default: begin
          // IDLE or DONE: err only lives for the DONE cycle.
          state_d = StIdle;
          err_d   = 1'b0;
          if (bus.start) begin
            state_d = StDone;
            if (bus.op > OP_LAST_LEGAL) begin
              err_d = 1'b1;
            end else if (bus.op == OpClr) begin
              dout_d = '0;
              sout_d = 1'b0;
            end else if (bus.op == OpLoad) begin
              dout_d = bus.din;
              sout_d = 1'b0;
            end else if (bus.amt != '0) begin
              cnt_d   = (bus.amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.amt;
              op_d    = op_e'(bus.op);
              state_d = StShift;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpClr;
      dout_q  <= '0;
      sout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
      err_q   <= err_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state_q == StShift);
  assign bus.done = (state_q == StDone);
  assign bus.err  = err_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit at WIDTH=8.
module tb_shift_seq_unit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  shift_seq_unit_if #(.WIDTH(8)) bus ();

  shift_seq_unit #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one enabled edge (the accept edge E0).
  task automatic issue(input logic [3:0] op, input logic [7:0] din, input logic [3:0] amt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.din   = din;
    bus.amt   = amt;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.din   = 8'h00;
    bus.amt   = 4'd0;
    bus.sin   = 1'b0;
    tick();
    check("rst_dout", 32'(bus.dout), 32'h00);
    check("rst_flags", {28'd0, bus.sout, bus.busy, bus.done, bus.err}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1. LOAD A5, ROR 3 -> B4, sout 1
    issue(4'd1, 8'hA5, 4'd0);
    check("load_done", 32'(bus.done), 32'h1);
    check("load_dout", 32'(bus.dout), 32'hA5);
    issue(4'd4, 8'h00, 4'd3);
    check("ror_busy_e0", {30'd0, bus.busy, bus.done}, 32'h2);
    check("ror_dout_e0", 32'(bus.dout), 32'hA5);
    tick();
    tick();
    check("ror_busy_e2", {30'd0, bus.busy, bus.done}, 32'h2);
    tick();
    check("ror_done_e3", {30'd0, bus.busy, bus.done}, 32'h1);
    check("ror_dout", 32'(bus.dout), 32'hB4);
    check("ror_sout", 32'(bus.sout), 32'h1);
    tick();
    check("ror_done_1cyc", 32'(bus.done), 32'h0);

    // 2. LOAD 80, SRA 10 clamped to 8 -> FF
    issue(4'd1, 8'h80, 4'd0);
    issue(4'd8, 8'h00, 4'd10);
    for (int i = 0; i < 7; i++) tick();
    check("sra_busy_e7", {30'd0, bus.busy, bus.done}, 32'h2);
    tick();
    check("sra_done_e8", {30'd0, bus.busy, bus.done}, 32'h1);
    check("sra_dout", 32'(bus.dout), 32'hFF);
    tick();

    // 3. CLR, SLI 4 with sin 1,0,1,1 -> 0B, sout 0
    issue(4'd0, 8'h00, 4'd0);
    check("clr_dout", 32'(bus.dout), 32'h00);
    issue(4'd7, 8'h00, 4'd4);
    bus.sin = 1'b1; tick();
    bus.sin = 1'b0; tick();
    check("sli_dout_e2", 32'(bus.dout), 32'h02);
    bus.sin = 1'b1; tick();
    bus.sin = 1'b1; tick();
    check("sli_done", 32'(bus.done), 32'h1);
    check("sli_dout", 32'(bus.dout), 32'h0B);
    check("sli_sout", 32'(bus.sout), 32'h0);
    bus.sin = 1'b0;
    tick();

    // 4. ROL 5 of 0B with a 2-cycle stall and a start while busy -> 61
    issue(4'd5, 8'h00, 4'd5);
    tick();
    bus.en    = 1'b0;
    bus.start = 1'b1;
    bus.op    = 4'd1;
    bus.din   = 8'h00;
    tick();
    tick();
    check("rol_stall_busy", {30'd0, bus.busy, bus.done}, 32'h2);
    check("rol_stall_dout", 32'(bus.dout), 32'h16);
    bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("rol_busy_e4", 32'(bus.busy), 32'h1);
    tick();
    check("rol_done", 32'(bus.done), 32'h1);
    check("rol_dout", 32'(bus.dout), 32'h61);
    check("rol_sout", 32'(bus.sout), 32'h1);
    bus.en = 1'b0;
    tick();
    check("done_hold_en0", 32'(bus.done), 32'h1);
    bus.en = 1'b1;
    tick();
    check("done_cleared", 32'(bus.done), 32'h0);

    // 5. Illegal op, then SLL amt 0
    issue(4'hF, 8'h00, 4'd2);
    check("ill_done_err", {30'd0, bus.done, bus.err}, 32'h3);
    check("ill_dout", 32'(bus.dout), 32'h61);
    tick();
    check("ill_cleared", {30'd0, bus.done, bus.err}, 32'h0);
    issue(4'd3, 8'h00, 4'd0);
    check("sll0_done_err", {30'd0, bus.done, bus.err}, 32'h2);
    check("sll0_dout", 32'(bus.dout), 32'h61);
    tick();

    // 6. Async reset in the middle of ROR 6
    issue(4'd1, 8'h3C, 4'd0);
    issue(4'd4, 8'h00, 4'd6);
    tick();
    tick();
    check("pre_rst_busy", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(bus.dout), 32'h00);
    check("async_rst_flags", {30'd0, bus.busy, bus.done}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(4'd1, 8'h5A, 4'd0);
    check("post_rst_load", {23'd0, bus.done, bus.dout}, 32'h15A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
